pc_sequencer: RTL and testbench

- Controls the program-counter register. Each cycle it selects next_pc: hold on stall, predicted branch target, or sequential PC + PC_INC.
- Prediction uses a table of 2-bit saturating counters indexed by PC.
- When the EX stage resolves a mispredicted branch, the block drives flush and the recovery address (save_pc, branch_pc) into the PC register and trains the predictor.
- Sits between IF predecode, EX branch resolution and the PC register.

---
 rtl/mips_pkg.sv | 29 ++
 rtl/pc_sequencer_bht.sv | 39 +++
 rtl/pc_sequencer.sv | 125 ++++++++++++
 tb/tb_pc_sequencer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: definitions shared by the PC sequencer and its branch history table.
//   - FSM state encoding (IDLE, RUN, RECOVER)
//   - 2-bit saturating counter values (SNT, WNT, WT, ST) and the BHT reset value
//   - ctr_update(): saturating counter step for a resolved branch outcome
package mips_pkg;

  localparam logic [1:0] IDLE    = 2'b00;
  localparam logic [1:0] RUN     = 2'b01;
  localparam logic [1:0] RECOVER = 2'b10;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  localparam logic [1:0] BHT_RESET = WNT;

  // Move a 2-bit counter one step toward the resolved outcome, clamping at the ends.
  function automatic logic [1:0] ctr_update(input logic [1:0] ctr, input logic taken);
    logic [1:0] res;
    if (taken) begin
      res = (ctr == ST) ? ST : ctr + 2'd1;
    end else begin
      res = (ctr == SNT) ? SNT : ctr - 2'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/pc_sequencer_bht.sv
// bht: branch history table of 2-bit saturating counters.
// Ports:
//   clk, reset       clock (rising edge), asynchronous active-low reset
//   rd_idx / rd_ctr  combinational read port
//   wr_en, wr_idx,   synchronous training port; the addressed counter steps
//   wr_taken         toward wr_taken with saturation
// A read of an entry being written in the same cycle returns the old value.
module bht
  import mips_pkg::*;
#(
  parameter int IDX_BITS = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [IDX_BITS-1:0] rd_idx,
  output logic [1:0]          rd_ctr,
  input  logic                wr_en,
  input  logic [IDX_BITS-1:0] wr_idx,
  input  logic                wr_taken
);

  localparam int ENTRIES = 1 << IDX_BITS;

  logic [1:0] ctr_r [ENTRIES];

  assign rd_ctr = ctr_r[rd_idx];

  // Counter array: all entries weakly not-taken on reset, trained on resolution.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_r[i] <= BHT_RESET;
      end
    end else if (wr_en) begin
      ctr_r[wr_idx] <= ctr_update(ctr_r[wr_idx], wr_taken);
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: chooses the next program counter and handles branch recovery.
// Ports:
//   clk, reset                  clock, asynchronous active-low reset
//   pc_add, stall               current PC, pipeline stall (hold PC)
//   if_is_branch, if_target     predecode info for the instruction at pc_add
//   ex_*                        branch resolution from the EX stage
//   next_pc, pred_taken         sequential/predicted next PC and the prediction
//   flush, save_pc, branch_pc   recovery request and (duplicated) recovery address
//   mispredict_cnt              saturating count of mispredictions
module pc_sequencer
  import mips_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int IDX_BITS     = 6,
  parameter int PC_INC       = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pc_add,
  input  logic             stall,
  input  logic             if_is_branch,
  input  logic [WIDTH-1:0] if_target,
  input  logic             ex_valid,
  input  logic             ex_is_branch,
  input  logic             ex_taken,
  input  logic             ex_pred_taken,
  input  logic [WIDTH-1:0] ex_pc,
  input  logic [WIDTH-1:0] ex_target,
  output logic [WIDTH-1:0] next_pc,
  output logic [WIDTH-1:0] save_pc,
  output logic [WIDTH-1:0] branch_pc,
  output logic             flush,
  output logic             pred_taken,
  output logic [15:0]      mispredict_cnt
);

  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  logic [1:0]       state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [1:0]       rd_ctr_s;
  logic             train_s;
  logic             mispredict_s;
  logic [WIDTH-1:0] rec_addr_s;

  bht #(.IDX_BITS(IDX_BITS)) u_bht (
    .clk      (clk),
    .reset    (reset),
    .rd_idx   (pc_add[IDX_BITS+1:2]),
    .rd_ctr   (rd_ctr_s),
    .wr_en    (train_s),
    .wr_idx   (ex_pc[IDX_BITS+1:2]),
    .wr_taken (ex_taken)
  );

  assign pred_taken = if_is_branch & rd_ctr_s[1];

  // Resolutions outside RUN come from squashed wrong-path instructions and are ignored.
  assign train_s      = (state_r == RUN) & ex_valid & ex_is_branch;
  assign mispredict_s = train_s & (ex_taken != ex_pred_taken);
  assign rec_addr_s   = ex_taken ? ex_target : ex_pc + WIDTH'(PC_INC);

  // Next-PC mux: hold, predicted target, or sequential increment.
  always_comb begin
    next_pc = pc_add + WIDTH'(PC_INC);
    if (stall || (state_r != RUN)) begin
      next_pc = pc_add;
    end else if (pred_taken) begin
      next_pc = if_target;
    end else begin
      next_pc = pc_add + WIDTH'(PC_INC);
    end
  end

  // Recovery FSM: flush stays high for FLUSH_CYCLES cycles after a mispredict.
  // Stall is deliberately not consulted, so a mispredict always redirects.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= IDLE;
      cnt_r     <= '0;
      flush     <= 1'b0;
      save_pc   <= '0;
      branch_pc <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          state_r <= RUN;
          flush   <= 1'b0;
        end
        RUN: begin
          if (mispredict_s) begin
            state_r   <= RECOVER;
            flush     <= 1'b1;
            save_pc   <= rec_addr_s;
            branch_pc <= rec_addr_s;
            cnt_r     <= CNT_W'(FLUSH_CYCLES - 1);
          end
        end
        RECOVER: begin
          if (cnt_r == '0) begin
            state_r <= RUN;
            flush   <= 1'b0;
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        default: begin
          state_r <= IDLE;
          flush   <= 1'b0;
        end
      endcase
    end
  end

  // Saturating mispredict statistic.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mispredict_cnt <= 16'd0;
    end else if (mispredict_s && (mispredict_cnt != 16'hFFFF)) begin
      mispredict_cnt <= mispredict_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed scenarios plus randomized traffic for pc_sequencer,
// checked every cycle against a behavioural model (counter table as an int
// array, recovery as "flush cycles remaining").
module tb_pc_sequencer;

  localparam int FC = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_add, if_target, ex_pc, ex_target;
  logic        stall, if_is_branch, ex_valid, ex_is_branch, ex_taken, ex_pred_taken;
  logic [31:0] next_pc, save_pc, branch_pc;
  logic        flush, pred_taken;
  logic [15:0] mispredict_cnt;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state.
  int          m_bht [64];
  bit          m_started;
  int          m_flush_left;
  logic [31:0] m_save;
  int          m_cnt;

  pc_sequencer #(.WIDTH(32), .IDX_BITS(6), .PC_INC(4), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .reset(reset), .pc_add(pc_add), .stall(stall),
    .if_is_branch(if_is_branch), .if_target(if_target),
    .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_taken(ex_taken),
    .ex_pred_taken(ex_pred_taken), .ex_pc(ex_pc), .ex_target(ex_target),
    .next_pc(next_pc), .save_pc(save_pc), .branch_pc(branch_pc),
    .flush(flush), .pred_taken(pred_taken), .mispredict_cnt(mispredict_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_bht[i] = 1;
    m_started    = 1'b0;
    m_flush_left = 0;
    m_save       = 32'd0;
    m_cnt        = 0;
  endtask

  function automatic bit m_run();
    return m_started && (m_flush_left == 0);
  endfunction

  // Compare every output with the model for the current inputs.
  task automatic compare_model();
    bit          exp_pred;
    logic [31:0] exp_next;
    exp_pred = if_is_branch && (m_bht[pc_add[7:2]] >= 2);
    if (stall || !m_run())  exp_next = pc_add;
    else if (exp_pred)      exp_next = if_target;
    else                    exp_next = pc_add + 32'd4;
    check_val("pred_taken", {31'd0, pred_taken}, {31'd0, exp_pred});
    check_val("next_pc", next_pc, exp_next);
    check_val("flush", {31'd0, flush}, {31'd0, (m_flush_left > 0)});
    check_val("save_pc", save_pc, m_save);
    check_val("branch_pc", branch_pc, m_save);
    check_val("mispredict_cnt", {16'd0, mispredict_cnt}, m_cnt);
  endtask

  // Advance the model across one rising edge using the current inputs.
  task automatic model_step();
    bit          live, mis;
    logic [31:0] rec;
    int          ix;
    live = m_run() && ex_valid && ex_is_branch;
    mis  = live && (ex_taken != ex_pred_taken);
    rec  = ex_taken ? ex_target : ex_pc + 32'd4;
    if (live) begin
      ix = ex_pc[7:2];
      if (ex_taken) m_bht[ix] = (m_bht[ix] == 3) ? 3 : m_bht[ix] + 1;
      else          m_bht[ix] = (m_bht[ix] == 0) ? 0 : m_bht[ix] - 1;
    end
    if (!m_started) begin
      m_started = 1'b1;
    end else if (m_flush_left > 0) begin
      m_flush_left--;
    end else if (mis) begin
      m_save       = rec;
      m_flush_left = FC;
      m_cnt        = (m_cnt == 65535) ? 65535 : m_cnt + 1;
    end
  endtask

  // One cycle: inputs already set after a falling edge.
  task automatic cycle();
    #1;
    compare_model();
    model_step();
    @(negedge clk);
  endtask

  task automatic set_quiet();
    stall = 1'b0; if_is_branch = 1'b0; if_target = 32'd0;
    ex_valid = 1'b0; ex_is_branch = 1'b0; ex_taken = 1'b0; ex_pred_taken = 1'b0;
    ex_pc = 32'd0; ex_target = 32'd0;
  endtask

  task automatic set_ex(input logic [31:0] pc, input logic tk, input logic ptk, input logic [31:0] tgt);
    ex_valid = 1'b1; ex_is_branch = 1'b1; ex_pc = pc;
    ex_taken = tk; ex_pred_taken = ptk; ex_target = tgt;
  endtask

  task automatic quiet_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      set_quiet();
      cycle();
    end
  endtask

  function automatic logic [31:0] rand_pc();
    int unsigned r;
    r = $urandom_range(0, 9);
    if (r == 0)      return 32'hFFFF_FFFC;
    else if (r == 1) return 32'($urandom);
    else             return 32'h200 + 32'($urandom_range(0, 15) << 2);
  endfunction

  initial begin
    set_quiet();
    pc_add = 32'h100;
    reset  = 1'b0;
    model_reset();
    #1;
    check_val("reset_flush", {31'd0, flush}, 32'd0);
    check_val("reset_cnt", {16'd0, mispredict_cnt}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // IDLE cycle holds PC, then sequential increment.
    #1 check_val("idle_next_pc", next_pc, 32'h100);
    cycle();
    #1 check_val("run_next_pc", next_pc, 32'h104);
    cycle();

    // Taken mispredict at 0x300.
    set_ex(32'h300, 1'b1, 1'b0, 32'h500);
    cycle();
    set_quiet();
    #1;
    check_val("mp_flush1", {31'd0, flush}, 32'd1);
    check_val("mp_save1", save_pc, 32'h500);
    check_val("mp_branch1", branch_pc, 32'h500);
    check_val("mp_cnt1", {16'd0, mispredict_cnt}, 32'd1);
    // Wrong-path resolution during RECOVER must be ignored.
    set_ex(32'h340, 1'b1, 1'b0, 32'h999);
    cycle();
    set_quiet();
    #1;
    check_val("mp_flush2", {31'd0, flush}, 32'd1);
    check_val("mp_save2", save_pc, 32'h500);
    check_val("mp_cnt2", {16'd0, mispredict_cnt}, 32'd1);
    cycle();
    #1 check_val("mp_flush_end", {31'd0, flush}, 32'd0);
    pc_add = 32'h340; if_is_branch = 1'b1; if_target = 32'h800;
    #1 check_val("recover_no_train", {31'd0, pred_taken}, 32'd0);
    cycle();

    // Not-taken mispredict with wrap of the recovery address.
    set_ex(32'hFFFF_FFFC, 1'b0, 1'b1, 32'h1234);
    cycle();
    set_quiet();
    #1 check_val("wrap_save", save_pc, 32'h0);
    check_val("wrap_flush", {31'd0, flush}, 32'd1);
    quiet_cycles(FC);

    // Train 0x200 taken twice, then predict taken to 0x400.
    set_ex(32'h200, 1'b1, 1'b0, 32'h400);
    cycle();
    quiet_cycles(FC);
    set_ex(32'h200, 1'b1, 1'b0, 32'h400);
    cycle();
    quiet_cycles(FC);
    pc_add = 32'h200; if_is_branch = 1'b1; if_target = 32'h400;
    #1;
    check_val("bht_pred", {31'd0, pred_taken}, 32'd1);
    check_val("bht_next_pc", next_pc, 32'h400);
    cycle();

    // Stall with a simultaneous mispredict still recovers.
    set_quiet();
    stall = 1'b1;
    set_ex(32'h280, 1'b1, 1'b0, 32'h600);
    cycle();
    set_quiet();
    #1 check_val("stall_mp_flush", {31'd0, flush}, 32'd1);
    check_val("stall_mp_save", save_pc, 32'h600);

    // Asynchronous reset in the middle of RECOVER.
    #2 reset = 1'b0;
    #1;
    check_val("arst_flush", {31'd0, flush}, 32'd0);
    check_val("arst_save", save_pc, 32'd0);
    check_val("arst_branch", branch_pc, 32'd0);
    check_val("arst_cnt", {16'd0, mispredict_cnt}, 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    quiet_cycles(1);

    // Every entry is weakly not-taken: one correct taken resolution flips it.
    for (int i = 0; i < 64; i++) begin
      set_quiet();
      set_ex(32'(i << 2), 1'b1, 1'b1, 32'h0);
      cycle();
      set_quiet();
      pc_add = 32'(i << 2); if_is_branch = 1'b1; if_target = 32'hABC0;
      #1 check_val("bht_reset_entry", {31'd0, pred_taken}, 32'd1);
      cycle();
    end

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      pc_add        = rand_pc();
      stall         = ($urandom_range(0, 4) == 0);
      if_is_branch  = ($urandom_range(0, 1) == 1);
      if_target     = 32'($urandom);
      ex_valid      = ($urandom_range(0, 3) != 0);
      ex_is_branch  = ($urandom_range(0, 2) != 0);
      ex_taken      = ($urandom_range(0, 1) == 1);
      ex_pred_taken = ($urandom_range(0, 3) == 0) ? ~ex_taken : ex_taken;
      ex_pc         = rand_pc();
      ex_target     = 32'($urandom);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
